// File: rtl/regbank_pkg.sv
// Shared types and defaults for the arbitrated register bank.
package regbank_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        ARB,
        LOCK
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_LOCK_MAX = 15;

endpackage

// File: rtl/regbank_arbiter_rr_arb2.sv
// Two-requester round-robin grant with a last-owner pointer.
// force_b hands port B exclusive ownership while a lock is held.
module rr_arb2
    import regbank_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic force_b,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_q;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        unique case (1'b1)
            force_b: begin
                gnt_b = req_b;
            end
            arb_en: begin
                if (req_a && req_b) begin
                    gnt_a = (last_q == PORT_B);
                    gnt_b = (last_q == PORT_A);
                end else begin
                    gnt_a = req_a;
                    gnt_b = req_b;
                end
            end
            default: ;
        endcase
    end

    // Leaving a lock always hands priority back to A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= PORT_B;
        end else if (force_b) begin
            last_q <= PORT_B;
        end else if (gnt_a) begin
            last_q <= PORT_A;
        end else if (gnt_b) begin
            last_q <= PORT_B;
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Register bank shared by the I2C slave (A) and the local core (B),
// with post-reset clear sweep, round-robin grant and a B lock.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              lock_b,
    output logic              busy,
    output logic              lock_timeout
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic [ADDR_W:0]  PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d, clr_nxt;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              relock_blk_q, relock_blk_d;
    logic              timeout_d;
    logic              arb_en, force_b;
    logic [DATA_W-1:0] mem [DEPTH];

    assign arb_en  = rst_n && (state_q == ARB);
    assign force_b = rst_n && (state_q == LOCK);
    assign busy    = !rst_n || (state_q == CLEAR);
    assign clr_nxt = clr_ptr_q + PTR_ONE;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (arb_en),
        .force_b (force_b),
        .req_a   (req_a),
        .req_b   (req_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    // A timed-out lock stays refused until B is seen with lock_b low.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        lock_cnt_d   = lock_cnt_q;
        relock_blk_d = relock_blk_q && lock_b;
        timeout_d    = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_nxt;
                if (clr_nxt[ADDR_W]) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (gnt_b && lock_b && !relock_blk_q) begin
                    state_d    = LOCK;
                    lock_cnt_d = CNT_ONE;
                end
            end
            LOCK: begin
                if (!lock_b) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CNT_MAX) begin
                    state_d      = ARB;
                    lock_cnt_d   = '0;
                    timeout_d    = 1'b1;
                    relock_blk_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            lock_cnt_q   <= '0;
            relock_blk_q <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_blk_q <= relock_blk_d;
            lock_timeout <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            rvalid_a <= gnt_a && !we_a;
            rvalid_b <= gnt_b && !we_b;
            if (gnt_a && !we_a) begin
                rdata_a <= mem[addr_a];
            end
            if (gnt_b && !we_b) begin
                rdata_b <= mem[addr_b];
            end
        end
    end

    // Grants are mutually exclusive, so at most one write per edge.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_ptr_q[ADDR_W-1:0]] <= '0;
        end else if (gnt_a && we_a) begin
            mem[addr_a] <= wdata_a;
        end else if (gnt_b && we_b) begin
            mem[addr_b] <= wdata_b;
        end
    end

endmodule
